// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS-subset controller: opcodes,
// FSM state encoding and the mux/ALU select encodings seen by the datapath.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADDR  = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_R_EXEC    = 4'd7,
    S_R_WB      = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_ADDI_EXEC = 4'd11,
    S_ADDI_WB   = 4'd12
  } state_t;

  // ALU operation request; 2'b10 is not used by this controller.
  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SL2 = 2'b11
  } srcb_t;

  typedef enum logic [1:0] {
    PCSRC_ALU    = 2'b00,
    PCSRC_ALUOUT = 2'b01,
    PCSRC_JUMP   = 2'b10
  } pcsrc_t;

  typedef struct packed {
    logic    pc_write;
    logic    pc_write_cond;
    logic    iord;
    logic    mem_read;
    logic    mem_write;
    logic    ir_write;
    logic    mem_to_reg;
    pcsrc_t  pc_source;
    alu_op_t alu_op;
    logic    alu_src_a;
    srcb_t   alu_src_b;
    logic    reg_write;
    logic    reg_dst;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_ctrl_decode.sv
// Combinational lookup from FSM state to the datapath control word.
// mem_ready only qualifies the FETCH-state IR/PC loads.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic       mem_ready,
  output ctrl_word_t ctrl
);

  // Every field defaults to 0 so unused controls never float.
  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        ctrl.alu_src_b = SRCB_IMM_SL2;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEM_READ: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCSRC_JUMP;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle sequencer: steps each instruction through fetch, decode,
// execute, memory and writeback, stalling on the memory ready handshake.
module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [5:0] Op_i,
  input  logic       mem_ready_i,
  output logic       PCWrite_o,
  output logic       PCWriteCond_o,
  output logic       IorD_o,
  output logic       MemRead_o,
  output logic       MemWrite_o,
  output logic       IRWrite_o,
  output logic       MemtoReg_o,
  output logic [1:0] PCSource_o,
  output logic [1:0] ALUOp_o,
  output logic       ALUSrcA_o,
  output logic [1:0] ALUSrcB_o,
  output logic       RegWrite_o,
  output logic       RegDst_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  state_t     state_reg, state_next;
  logic       illegal_reg, illegal_next;
  ctrl_word_t ctrl;

  // State and sticky illegal flag; reset abandons any instruction in flight.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_reg   <= S_IDLE;
      illegal_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      illegal_reg <= illegal_next;
    end
  end

  // Next-state selection; start_i only matters in IDLE.
  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    unique case (state_reg)
      S_IDLE:      if (start_i) state_next = S_FETCH;
      S_FETCH:     if (mem_ready_i) state_next = S_DECODE;
      S_DECODE: begin
        case (Op_i)
          OP_LW, OP_SW: state_next = S_MEM_ADDR;
          OP_RTYPE:     state_next = S_R_EXEC;
          OP_BEQ:       state_next = S_BRANCH;
          OP_J:         state_next = S_JUMP;
          OP_ADDI:      state_next = S_ADDI_EXEC;
          default: begin
            state_next   = S_FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR:  state_next = (Op_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready_i) state_next = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready_i) state_next = S_FETCH;
      S_R_EXEC:    state_next = S_R_WB;
      S_ADDI_EXEC: state_next = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_ADDI_WB, S_BRANCH, S_JUMP: state_next = S_FETCH;
      default:     state_next = S_IDLE;
    endcase
  end

  ctrl_decode u_decode (
    .state     (state_reg),
    .mem_ready (mem_ready_i),
    .ctrl      (ctrl)
  );

  assign PCWrite_o     = ctrl.pc_write;
  assign PCWriteCond_o = ctrl.pc_write_cond;
  assign IorD_o        = ctrl.iord;
  assign MemRead_o     = ctrl.mem_read;
  assign MemWrite_o    = ctrl.mem_write;
  assign IRWrite_o     = ctrl.ir_write;
  assign MemtoReg_o    = ctrl.mem_to_reg;
  assign PCSource_o    = ctrl.pc_source;
  assign ALUOp_o       = ctrl.alu_op;
  assign ALUSrcA_o     = ctrl.alu_src_a;
  assign ALUSrcB_o     = ctrl.alu_src_b;
  assign RegWrite_o    = ctrl.reg_write;
  assign RegDst_o      = ctrl.reg_dst;
  assign illegal_o     = illegal_reg;
  assign state_o       = state_reg;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed and random
// instruction streams checked cycle by cycle against a step-list model.
module tb_multicycle_control;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [5:0] op;
  logic       mem_ready;
  logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic       mem_to_reg, alu_src_a, reg_write, reg_dst, illegal;
  logic [1:0] pc_source, alu_op, alu_src_b;
  logic [3:0] state;

  int n_cmp = 0;
  int n_err = 0;
  logic ill_model = 1'b0;

  typedef struct {
    state_t st;
    logic   rdy;
  } step_t;

  step_t q[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .start_i       (start),
    .Op_i          (op),
    .mem_ready_i   (mem_ready),
    .PCWrite_o     (pc_write),
    .PCWriteCond_o (pc_write_cond),
    .IorD_o        (iord),
    .MemRead_o     (mem_read),
    .MemWrite_o    (mem_write),
    .IRWrite_o     (ir_write),
    .MemtoReg_o    (mem_to_reg),
    .PCSource_o    (pc_source),
    .ALUOp_o       (alu_op),
    .ALUSrcA_o     (alu_src_a),
    .ALUSrcB_o     (alu_src_b),
    .RegWrite_o    (reg_write),
    .RegDst_o      (reg_dst),
    .illegal_o     (illegal),
    .state_o       (state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] observed_word();
    return {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
            mem_to_reg, pc_source, alu_op, alu_src_a, alu_src_b, reg_write, reg_dst};
  endfunction

  // Required outputs per state, straight from the control table.
  function automatic logic [15:0] spec_word(input state_t st, input logic rdy);
    logic pcw, pcwc, io, mr, mw, irw, m2r, sa, rw, rd;
    logic [1:0] ps, ao, sb;
    {pcw, pcwc, io, mr, mw, irw, m2r, sa, rw, rd} = '0;
    ps = 2'b00; ao = 2'b00; sb = 2'b00;
    case (st)
      S_FETCH:     begin mr = 1'b1; sb = 2'b01; irw = rdy; pcw = rdy; end
      S_DECODE:    sb = 2'b11;
      S_MEM_ADDR:  begin sa = 1'b1; sb = 2'b10; end
      S_MEM_READ:  begin mr = 1'b1; io = 1'b1; end
      S_MEM_WB:    begin rw = 1'b1; m2r = 1'b1; end
      S_MEM_WRITE: begin mw = 1'b1; io = 1'b1; end
      S_R_EXEC:    begin sa = 1'b1; ao = 2'b11; end
      S_R_WB:      begin rw = 1'b1; rd = 1'b1; end
      S_ADDI_EXEC: begin sa = 1'b1; sb = 2'b10; end
      S_ADDI_WB:   rw = 1'b1;
      S_BRANCH:    begin sa = 1'b1; ao = 2'b01; pcwc = 1'b1; ps = 2'b01; end
      S_JUMP:      begin pcw = 1'b1; ps = 2'b10; end
      default:     ;
    endcase
    return {pcw, pcwc, io, mr, mw, irw, m2r, ps, ao, sa, sb, rw, rd};
  endfunction

  function automatic logic supported(input logic [5:0] o);
    return o inside {6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
  endfunction

  function automatic step_t mk(input state_t st, input logic rdy);
    step_t s;
    s.st = st;
    s.rdy = rdy;
    return s;
  endfunction

  // Expected step list for one instruction with fw/mw not-ready cycles.
  task automatic plan(input logic [5:0] o, input int fw, input int mw);
    q.delete();
    for (int i = 0; i < fw; i++) q.push_back(mk(S_FETCH, 1'b0));
    q.push_back(mk(S_FETCH, 1'b1));
    q.push_back(mk(S_DECODE, 1'($urandom)));
    case (o)
      6'h00: begin q.push_back(mk(S_R_EXEC, 1'($urandom))); q.push_back(mk(S_R_WB, 1'($urandom))); end
      6'h08: begin q.push_back(mk(S_ADDI_EXEC, 1'($urandom))); q.push_back(mk(S_ADDI_WB, 1'($urandom))); end
      6'h04: q.push_back(mk(S_BRANCH, 1'($urandom)));
      6'h02: q.push_back(mk(S_JUMP, 1'($urandom)));
      6'h23: begin
        q.push_back(mk(S_MEM_ADDR, 1'($urandom)));
        for (int i = 0; i < mw; i++) q.push_back(mk(S_MEM_READ, 1'b0));
        q.push_back(mk(S_MEM_READ, 1'b1));
        q.push_back(mk(S_MEM_WB, 1'($urandom)));
      end
      6'h2b: begin
        q.push_back(mk(S_MEM_ADDR, 1'($urandom)));
        for (int i = 0; i < mw; i++) q.push_back(mk(S_MEM_WRITE, 1'b0));
        q.push_back(mk(S_MEM_WRITE, 1'b1));
      end
      default: ;
    endcase
  endtask

  // Called #1 after a rising edge with the DUT in FETCH; returns likewise.
  task automatic run_instr(input logic [5:0] o, input int fw, input int mw, input bit drop_start);
    int irw_n = 0, rw_n = 0, mw_n = 0, pcw_n = 0, pcwc_n = 0;
    plan(o, fw, mw);
    for (int k = 0; k < q.size(); k++) begin
      op = o;
      mem_ready = q[k].rdy;
      if (drop_start && k == 1) start = 1'b0;
      #1;
      check($sformatf("state op=%h step=%0d", o, k), 32'(state), 32'(q[k].st));
      check($sformatf("ctrl op=%h step=%0d", o, k), 32'(observed_word()), 32'(spec_word(q[k].st, q[k].rdy)));
      check($sformatf("illegal op=%h step=%0d", o, k), 32'(illegal), 32'(ill_model));
      irw_n  += int'(ir_write);
      rw_n   += int'(reg_write);
      mw_n   += int'(mem_write);
      pcw_n  += int'(pc_write);
      pcwc_n += int'(pc_write_cond);
      if (q[k].st == S_DECODE && !supported(o)) ill_model = 1'b1;
      @(posedge clk);
      #1;
    end
    check($sformatf("irwrite_pulses op=%h", o), 32'(irw_n), 32'd1);
    check($sformatf("regwrite_cycles op=%h", o), 32'(rw_n), (o inside {6'h00, 6'h08, 6'h23}) ? 32'd1 : 32'd0);
    check($sformatf("memwrite_cycles op=%h", o), 32'(mw_n), (o == 6'h2b) ? 32'(mw + 1) : 32'd0);
    check($sformatf("pcwrite_cycles op=%h", o), 32'(pcw_n), (o == 6'h02) ? 32'd2 : 32'd1);
    check($sformatf("pcwritecond_cycles op=%h", o), 32'(pcwc_n), (o == 6'h04) ? 32'd1 : 32'd0);
    $display("instr op=%h fetch_wait=%0d mem_wait=%0d cycles=%0d", o, fw, mw, q.size());
  endtask

  initial begin
    logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h08};
    logic [5:0] r_op;
    rst_n = 1'b0;
    start = 1'b0;
    op = 6'h00;
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'(state), 32'(S_IDLE));
    check("reset_ctrl", 32'(observed_word()), 32'd0);
    check("reset_illegal", 32'(illegal), 32'd0);

    // Held in IDLE while start is low, even with ready high.
    rst_n = 1'b1;
    mem_ready = 1'b1;
    @(posedge clk);
    #1;
    check("idle_hold_state", 32'(state), 32'(S_IDLE));
    check("idle_hold_ctrl", 32'(observed_word()), 32'd0);
    start = 1'b1;
    @(posedge clk);
    #1;

    // Directed instructions.
    run_instr(6'h00, 0, 0, 1'b0);
    run_instr(6'h23, 2, 3, 1'b0);
    run_instr(6'h2b, 0, 2, 1'b0);
    run_instr(6'h04, 0, 0, 1'b0);
    run_instr(6'h02, 0, 0, 1'b0);
    run_instr(6'h3f, 0, 0, 1'b0);
    run_instr(6'h08, 1, 0, 1'b0);

    // Random stream; start is dropped partway and must have no effect.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 6) == 6) begin
        r_op = 6'($urandom_range(0, 63));
        while (supported(r_op)) r_op = 6'($urandom_range(0, 63));
      end else begin
        r_op = ops[$urandom_range(0, 5)];
      end
      run_instr(r_op, $urandom_range(0, 2), $urandom_range(0, 3), n == 10);
    end

    // Reset in the middle of a stalled load.
    op = 6'h23;
    mem_ready = 1'b1;
    #1;
    check("rst_pre_fetch", 32'(state), 32'(S_FETCH));
    @(posedge clk); #1;
    check("rst_pre_decode", 32'(state), 32'(S_DECODE));
    @(posedge clk); #1;
    check("rst_pre_addr", 32'(state), 32'(S_MEM_ADDR));
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_pre_memread", 32'(state), 32'(S_MEM_READ));
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    ill_model = 1'b0;
    check("rst_mid_state", 32'(state), 32'(S_IDLE));
    check("rst_mid_ctrl", 32'(observed_word()), 32'd0);
    check("rst_mid_illegal", 32'(illegal), 32'd0);
    mem_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (c == 1) rst_n = 1'b1;
      #1;
      check($sformatf("rst_after_regwrite c=%0d", c), 32'(reg_write), 32'd0);
      check($sformatf("rst_after_state c=%0d", c), 32'(state), 32'(S_IDLE));
    end
    $display("reset mid-lw abandoned instruction");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
